// File: rtl/cmp_pkg.sv
// Shared types for the serial magnitude comparator: FSM states and one-hot result codes.
package cmp_pkg;

   typedef enum logic {
      CMP_IDLE    = 1'b0,
      CMP_COMPARE = 1'b1
   } cmp_state_e;

   localparam int unsigned RES_W = 3;

   // One-hot result code, bit order {gt, eq, lt}
   localparam logic [RES_W-1:0] RES_NONE = 3'b000;
   localparam logic [RES_W-1:0] RES_GT   = 3'b100;
   localparam logic [RES_W-1:0] RES_EQ   = 3'b010;
   localparam logic [RES_W-1:0] RES_LT   = 3'b001;

endpackage

// File: rtl/serial_magnitude_comparator_if.sv
// Request/result bundle between the operand registers and the comparator.
interface serial_magnitude_comparator_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic             signed_mode;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             a_gt_b;
   logic             a_eq_b;
   logic             a_lt_b;

   modport master (
      output start, signed_mode, a, b,
      input  busy, done, a_gt_b, a_eq_b, a_lt_b
   );

   modport slave (
      input  start, signed_mode, a, b,
      output busy, done, a_gt_b, a_eq_b, a_lt_b
   );
endinterface

// File: rtl/digit_compare.sv
// Combinational unsigned compare of one DIGIT-bit slice of each operand.
module digit_compare #(
   parameter int unsigned DIGIT = 2
) (
   input  logic [DIGIT-1:0] i_a,
   input  logic [DIGIT-1:0] i_b,
   output logic             o_gt,
   output logic             o_eq,
   output logic             o_lt
);
   assign o_gt = (i_a > i_b);
   assign o_eq = (i_a == i_b);
   assign o_lt = (i_a < i_b);
endmodule

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks the latched operands MSB-first, DIGIT bits
// per clock, and stops at the first differing digit.
module serial_magnitude_comparator
   import cmp_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 2
) (
   input logic                          clk,
   input logic                          rst,
   serial_magnitude_comparator_if.slave bus
);
   localparam int unsigned NDIG = WIDTH / DIGIT;
   localparam int unsigned KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NDIG - 1);

   generate
      if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
         $error("serial_magnitude_comparator: WIDTH must be a non-zero multiple of DIGIT");
      end
   endgenerate

   cmp_state_e       r_state, w_state_nxt;
   logic [KW-1:0]    r_k, w_k_nxt;
   logic [WIDTH-1:0] r_a, w_a_nxt;
   logic [WIDTH-1:0] r_b, w_b_nxt;
   logic             r_busy, w_busy_nxt;
   logic             r_done, w_done_nxt;
   logic [RES_W-1:0] r_res, w_res_nxt;

   logic [WIDTH-1:0] w_a_sh, w_b_sh;
   logic [DIGIT-1:0] w_a_dig, w_b_dig;
   logic             w_dig_gt, w_dig_eq, w_dig_lt;
   logic [WIDTH-1:0] w_sign_flip;

   // Signed mode biases both operands by flipping the MSB so an unsigned walk orders them correctly
   assign w_sign_flip = WIDTH'(bus.signed_mode) << (WIDTH - 1);

   assign w_a_sh  = r_a << (DIGIT * 32'(r_k));
   assign w_b_sh  = r_b << (DIGIT * 32'(r_k));
   assign w_a_dig = w_a_sh[WIDTH-1 -: DIGIT];
   assign w_b_dig = w_b_sh[WIDTH-1 -: DIGIT];

   digit_compare #(.DIGIT(DIGIT)) u_digit_compare (
      .i_a  (w_a_dig),
      .i_b  (w_b_dig),
      .o_gt (w_dig_gt),
      .o_eq (w_dig_eq),
      .o_lt (w_dig_lt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= CMP_IDLE;
         r_k     <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_res   <= RES_NONE;
      end else begin
         r_state <= w_state_nxt;
         r_k     <= w_k_nxt;
         r_a     <= w_a_nxt;
         r_b     <= w_b_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_res   <= w_res_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_k_nxt     = r_k;
      w_a_nxt     = r_a;
      w_b_nxt     = r_b;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      w_res_nxt   = r_res;

      case (r_state)
         CMP_IDLE: begin
            if (bus.start) begin
               w_a_nxt     = bus.a ^ w_sign_flip;
               w_b_nxt     = bus.b ^ w_sign_flip;
               w_k_nxt     = '0;
               w_busy_nxt  = 1'b1;
               w_res_nxt   = RES_NONE;
               w_state_nxt = CMP_COMPARE;
            end
         end
         CMP_COMPARE: begin
            if (w_dig_gt) begin
               w_res_nxt   = RES_GT;
               w_done_nxt  = 1'b1;
               w_busy_nxt  = 1'b0;
               w_state_nxt = CMP_IDLE;
            end else if (w_dig_lt) begin
               w_res_nxt   = RES_LT;
               w_done_nxt  = 1'b1;
               w_busy_nxt  = 1'b0;
               w_state_nxt = CMP_IDLE;
            end else if (w_dig_eq && (r_k == K_LAST)) begin
               w_res_nxt   = RES_EQ;
               w_done_nxt  = 1'b1;
               w_busy_nxt  = 1'b0;
               w_state_nxt = CMP_IDLE;
            end else begin
               w_k_nxt = r_k + KW'(1);
            end
         end
         default: w_state_nxt = CMP_IDLE;
      endcase
   end

   assign bus.busy   = r_busy;
   assign bus.done   = r_done;
   assign bus.a_gt_b = |(r_res & RES_GT);
   assign bus.a_eq_b = |(r_res & RES_EQ);
   assign bus.a_lt_b = |(r_res & RES_LT);

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Bench for serial_magnitude_comparator: 8-bit/2-bit-digit and 1-bit/1-bit-digit instances.
module tb_serial_magnitude_comparator;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   serial_magnitude_comparator_if #(.WIDTH(8)) if8();
   serial_magnitude_comparator_if #(.WIDTH(1)) if1();

   serial_magnitude_comparator #(.WIDTH(8), .DIGIT(2)) u_dut8 (
      .clk (clk),
      .rst (rst),
      .bus (if8)
   );

   serial_magnitude_comparator #(.WIDTH(1), .DIGIT(1)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (if1)
   );

   always #5 clk = ~clk;

   // Reference: ordering from plain (signed or unsigned) arithmetic; latency is one plus
   // the number of leading base-4 digits that agree once signed values are offset by 128
   function automatic void model8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                                  output int lat, output logic [2:0] res);
      int ua, ub, div;
      bit found;
      ua    = sm ? (int'(a) + 128) % 256 : int'(a);
      ub    = sm ? (int'(b) + 128) % 256 : int'(b);
      lat   = 4;
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
         div = 4 ** (3 - k);
         if (!found && ((ua / div) % 4) != ((ub / div) % 4)) begin
            lat   = k + 1;
            found = 1'b1;
         end
      end
      if (sm)
         res = ($signed(a) > $signed(b)) ? 3'b100 : ($signed(a) == $signed(b)) ? 3'b010 : 3'b001;
      else
         res = (a > b) ? 3'b100 : (a == b) ? 3'b010 : 3'b001;
   endfunction

   // Issue one request on the 8-bit instance; a/b are scrambled while it is busy
   task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                         output int lat, output logic [4:0] at_acc, output logic [2:0] res);
      @(posedge clk); #1;
      if8.start = 1'b1; if8.a = a; if8.b = b; if8.signed_mode = sm;
      @(posedge clk); #1;
      if8.start = 1'b0;
      at_acc = {if8.busy, if8.done, if8.a_gt_b, if8.a_eq_b, if8.a_lt_b};
      lat = 0;
      while (!if8.done && lat < 40) begin
         if8.a = 8'($urandom); if8.b = 8'($urandom); if8.signed_mode = 1'($urandom);
         @(posedge clk); #1;
         lat++;
      end
      res = {if8.a_gt_b, if8.a_eq_b, if8.a_lt_b};
   endtask

   task automatic drive1(input logic a, input logic b, output int lat, output logic [2:0] res);
      @(posedge clk); #1;
      if1.start = 1'b1; if1.a = a; if1.b = b; if1.signed_mode = 1'b0;
      @(posedge clk); #1;
      if1.start = 1'b0;
      lat = 0;
      while (!if1.done && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      res = {if1.a_gt_b, if1.a_eq_b, if1.a_lt_b};
   endtask

   task automatic test_reset();
      logic [4:0] o8, o1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      o8 = {if8.busy, if8.done, if8.a_gt_b, if8.a_eq_b, if8.a_lt_b};
      o1 = {if1.busy, if1.done, if1.a_gt_b, if1.a_eq_b, if1.a_lt_b};
      total++;
      if (o8 !== 5'b00000) begin bad++; $display("FAIL reset8: got %b want 00000", o8); end
      total++;
      if (o1 !== 5'b00000) begin bad++; $display("FAIL reset1: got %b want 00000", o1); end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_reset_abort();
      logic [4:0] o8;
      bit         saw_done;
      @(posedge clk); #1;
      if8.start = 1'b1; if8.a = 8'h5A; if8.b = 8'h5A; if8.signed_mode = 1'b0;
      @(posedge clk); #1;
      if8.start = 1'b0;
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      o8 = {if8.busy, if8.done, if8.a_gt_b, if8.a_eq_b, if8.a_lt_b};
      total++;
      if (o8 !== 5'b00000) begin bad++; $display("FAIL abort_immediate: got %b want 00000", o8); end
      @(negedge clk); rst = 1'b0;
      saw_done = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         if (if8.done) saw_done = 1'b1;
      end
      total++;
      if (saw_done !== 1'b0) begin bad++; $display("FAIL abort_no_done: got %b want 0", saw_done); end
   endtask

   task automatic test_equal();
      int lat; logic [4:0] acc; logic [2:0] res; logic [3:0] hold;
      drive8(8'h5A, 8'h5A, 1'b0, lat, acc, res);
      total++;
      if (acc !== 5'b10000) begin bad++; $display("FAIL eq_accept: got %b want 10000", acc); end
      total++;
      if (lat !== 4) begin bad++; $display("FAIL eq_latency: got %0d want 4", lat); end
      total++;
      if (res !== 3'b010) begin bad++; $display("FAIL eq_flags: got %b want 010", res); end
      @(posedge clk); #1;
      hold = {if8.done, if8.a_gt_b, if8.a_eq_b, if8.a_lt_b};
      total++;
      if (hold !== 4'b0010) begin bad++; $display("FAIL eq_hold: got %b want 0010", hold); end
   endtask

   task automatic test_early_exit();
      int lat; logic [4:0] acc; logic [2:0] res;
      drive8(8'hC0, 8'h3F, 1'b0, lat, acc, res);
      total++;
      if (lat !== 1) begin bad++; $display("FAIL early_u_latency: got %0d want 1", lat); end
      total++;
      if (res !== 3'b100) begin bad++; $display("FAIL early_u_flags: got %b want 100", res); end
      drive8(8'hC0, 8'h3F, 1'b1, lat, acc, res);
      total++;
      if (lat !== 1) begin bad++; $display("FAIL early_s_latency: got %0d want 1", lat); end
      total++;
      if (res !== 3'b001) begin bad++; $display("FAIL early_s_flags: got %b want 001", res); end
   endtask

   task automatic test_back_to_back();
      int lat; logic [4:0] o;
      @(posedge clk); #1;
      if8.start = 1'b1; if8.a = 8'h12; if8.b = 8'h13; if8.signed_mode = 1'b0;
      @(posedge clk); #1;
      if8.a = 8'hFF;
      total++;
      if (if8.busy !== 1'b1) begin bad++; $display("FAIL b2b_busy: got %b want 1", if8.busy); end
      @(posedge clk); #1;
      if8.start = 1'b0;
      lat = 1;
      while (!if8.done && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      total++;
      if (lat !== 4) begin bad++; $display("FAIL b2b_latency: got %0d want 4", lat); end
      o = {if8.busy, if8.done, if8.a_gt_b, if8.a_eq_b, if8.a_lt_b};
      total++;
      if (o !== 5'b01001) begin bad++; $display("FAIL b2b_first: got %b want 01001", o); end
      if8.start = 1'b1; if8.a = 8'h80; if8.b = 8'h7F; if8.signed_mode = 1'b0;
      @(posedge clk); #1;
      if8.start = 1'b0;
      o = {if8.busy, if8.done, if8.a_gt_b, if8.a_eq_b, if8.a_lt_b};
      total++;
      if (o !== 5'b10000) begin bad++; $display("FAIL b2b_accept: got %b want 10000", o); end
      @(posedge clk); #1;
      o = {if8.busy, if8.done, if8.a_gt_b, if8.a_eq_b, if8.a_lt_b};
      total++;
      if (o !== 5'b01100) begin bad++; $display("FAIL b2b_second: got %b want 01100", o); end
   endtask

   task automatic test_random();
      int lat, exp_lat; logic [4:0] acc; logic [2:0] res, exp_res;
      logic [7:0] a, b; logic sm;
      for (int n = 0; n < 40; n++) begin
         a  = 8'($urandom);
         b  = (n % 4 == 0) ? a : ((n % 4 == 1) ? (a ^ 8'($urandom_range(0, 3))) : 8'($urandom));
         sm = 1'($urandom);
         model8(a, b, sm, exp_lat, exp_res);
         drive8(a, b, sm, lat, acc, res);
         total++;
         if (acc !== 5'b10000) begin bad++; $display("FAIL rnd_accept a=%h b=%h s=%b: got %b want 10000", a, b, sm, acc); end
         total++;
         if (lat !== exp_lat) begin bad++; $display("FAIL rnd_latency a=%h b=%h s=%b: got %0d want %0d", a, b, sm, lat, exp_lat); end
         total++;
         if (res !== exp_res) begin bad++; $display("FAIL rnd_flags a=%h b=%h s=%b: got %b want %b", a, b, sm, res, exp_res); end
      end
   endtask

   task automatic test_width1();
      int lat; logic [2:0] res, exp_res; logic a, b;
      for (int n = 0; n < 4; n++) begin
         a = n[1];
         b = n[0];
         exp_res = (a > b) ? 3'b100 : (a == b) ? 3'b010 : 3'b001;
         drive1(a, b, lat, res);
         total++;
         if (lat !== 1) begin bad++; $display("FAIL w1_latency ab=%b%b: got %0d want 1", a, b, lat); end
         total++;
         if (res !== exp_res) begin bad++; $display("FAIL w1_flags ab=%b%b: got %b want %b", a, b, res, exp_res); end
      end
   endtask

   initial begin
      clk = 1'b0;
      rst = 1'b1;
      total = 0;
      bad = 0;
      if8.start = 1'b0; if8.signed_mode = 1'b0; if8.a = '0; if8.b = '0;
      if1.start = 1'b0; if1.signed_mode = 1'b0; if1.a = '0; if1.b = '0;
      test_reset();
      test_reset_abort();
      test_equal();
      test_early_exit();
      test_back_to_back();
      test_random();
      test_width1();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
